// File: rtl/vertical_node_mc_pkg.sv
// ---------------------------------------------------------------------------
// vnode_pkg
// Shared helpers for the vertical_node_mc reduction node:
//   lane_w    : lane word width from integer/fractional bit counts
//   sat_max   : largest signed value of a w-bit word (wide_t)
//   sat_min   : smallest signed value of a w-bit word (wide_t)
//   is_ovf    : 1 when a wide signed value does not fit in w bits
//   saturate  : clamp a wide signed value into the w-bit signed range
// Values are carried in a fixed 64-bit signed container (wide_t) so the
// helpers work for any lane width up to 63 bits.
// ---------------------------------------------------------------------------
package vnode_pkg;

   localparam int MAX_D = 63;

   typedef logic signed [MAX_D:0] wide_t;

   function automatic int lane_w(input int iw, input int fw);
      return iw + fw;
   endfunction

   function automatic wide_t sat_max(input int w);
      wide_t one;
      one = 64'sd1;
      return (one <<< (w - 1)) - one;
   endfunction

   function automatic wide_t sat_min(input int w);
      return ~sat_max(w);
   endfunction

   // Saturation limits for the default 8.8 lane format.
   localparam int    D_DEF   = lane_w(8, 8);
   localparam wide_t SAT_MAX = sat_max(D_DEF);
   localparam wide_t SAT_MIN = sat_min(D_DEF);

   function automatic logic is_ovf(input wide_t v, input int w);
      return (v > sat_max(w)) || (v < sat_min(w));
   endfunction

   function automatic wide_t saturate(input wide_t v, input int w);
      wide_t hi;
      wide_t lo;
      hi = sat_max(w);
      lo = sat_min(w);
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/vertical_node_mc_lane.sv
// ---------------------------------------------------------------------------
// vnode_lane
// One lane of the vertical node: selects bypass / add / local operand,
// optionally accumulates over several beats, and holds the lane's output
// word and sticky overflow flag.
// Build option: VNODE_SAT_EN -- when defined, overflowing add/accumulate
// results clamp to the signed range and set ovf; otherwise results wrap and
// ovf is tied low.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   en_adder, sel_mux   registered lane configuration
//   beat                an input beat is accepted this cycle
//   first               this beat starts a new accumulation
//   load_out            this beat is final; capture the result
//   clr                 configuration load: clear accumulator and ovf
//   top, mux            lane operands
//   out                 registered lane result
//   ovf                 sticky overflow flag
// ---------------------------------------------------------------------------
module vnode_lane
   import vnode_pkg::*;
#(
   parameter int D = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_adder,
   input  logic                sel_mux,
   input  logic                beat,
   input  logic                first,
   input  logic                load_out,
   input  logic                clr,
   input  logic signed [D-1:0] top,
   input  logic signed [D-1:0] mux,
   output logic signed [D-1:0] out,
   output logic                ovf
);

   logic signed [D-1:0] r;
   logic signed [D-1:0] acc_next;
   logic signed [D-1:0] acc_p1;
   logic signed [D-1:0] out_p1;

`ifdef VNODE_SAT_EN
   logic signed [D:0] r_full;
   logic signed [D:0] acc_full;
   wide_t             r_w;
   wide_t             a_w;
   logic              ovf_step;
   logic              ovf_p1;

   // Sums are formed at D+1 bits so the true result is always visible
   // before clamping.
   always_comb begin
      r_full = $signed({mux[D-1], mux});
      if (sel_mux)
         r_full = $signed({top[D-1], top});
      else if (en_adder)
         r_full = $signed({top[D-1], top}) + $signed({mux[D-1], mux});
      r_w = wide_t'(r_full);
      r   = D'(saturate(r_w, D));

      acc_full = $signed({r[D-1], r});
      if (!first)
         acc_full = $signed({acc_p1[D-1], acc_p1}) + $signed({r[D-1], r});
      a_w      = wide_t'(acc_full);
      acc_next = D'(saturate(a_w, D));

      ovf_step = is_ovf(r_w, D) | is_ovf(a_w, D);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clr)
         ovf_p1 <= 1'b0;
      else if (beat && ovf_step)
         ovf_p1 <= 1'b1;
   end

   assign ovf = ovf_p1;
`else
   always_comb begin
      r = mux;
      if (sel_mux)
         r = top;
      else if (en_adder)
         r = top + mux;
      acc_next = first ? r : acc_p1 + r;
   end

   assign ovf = 1'b0;
`endif

   // ---- stage 1: accumulator and output word ----
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         acc_p1 <= '0;
         out_p1 <= '0;
      end else begin
         if (clr)
            acc_p1 <= '0;
         else if (beat)
            acc_p1 <= acc_next;
         if (load_out)
            out_p1 <= acc_next;
      end
   end

   assign out = out_p1;

endmodule

// File: rtl/vertical_node_mc.sv
// ---------------------------------------------------------------------------
// vertical_node_mc
// Multi-lane handshaked vertical adder node for the systolic PE column.
// Per lane: bypass the top operand, or add top + local operand, optionally
// accumulating over acc_len beats. Configuration is forwarded downward.
// Build option: VNODE_SAT_EN selects saturating arithmetic with sticky
// per-lane overflow flags (default: wrapping arithmetic, ovf_o = 0).
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   path_ld_i                   load config/acc_len, abort accumulation
//   en_adder_i, sel_mux_i       per-lane config inputs
//   acc_len_i                   beats per output
//   en_adder_o, sel_mux_o       registered config for the next node
//   top_data_i, mux_data_i      lane operands, lane k at [k*D +: D]
//   valid_i / ready_o           input beat handshake
//   out_data_o, valid_o/ready_i output handshake
//   ovf_o                       per-lane sticky overflow
// ---------------------------------------------------------------------------
module vertical_node_mc
   import vnode_pkg::*;
#(
   parameter int F_WIDTH   = 8,
   parameter int I_WIDTH   = 8,
   parameter int LANES     = 4,
   parameter int ACC_LEN_W = 4,
   localparam int D        = lane_w(I_WIDTH, F_WIDTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 path_ld_i,
   input  logic [LANES-1:0]     en_adder_i,
   input  logic [LANES-1:0]     sel_mux_i,
   input  logic [ACC_LEN_W-1:0] acc_len_i,
   output logic [LANES-1:0]     en_adder_o,
   output logic [LANES-1:0]     sel_mux_o,
   input  logic [LANES*D-1:0]   top_data_i,
   input  logic [LANES*D-1:0]   mux_data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [LANES*D-1:0]   out_data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [LANES-1:0]     ovf_o
);

   logic [LANES-1:0]     en_cfg_p1;
   logic [LANES-1:0]     sel_cfg_p1;
   logic [ACC_LEN_W-1:0] acc_len_p1;
   logic [ACC_LEN_W-1:0] cnt_p1;
   logic                 vld_p1;

   logic single;
   logic final_beat;
   logic first;
   logic accept;
   logic new_final;

   // acc_len of 0 or 1 makes every beat final.
   assign single     = (acc_len_p1 <= ACC_LEN_W'(1));
   assign final_beat = single | (cnt_p1 == acc_len_p1 - ACC_LEN_W'(1));
   assign first      = single | (cnt_p1 == '0);

   // A non-final beat never touches the output register, so it may be
   // taken even while the output is stalled.
   assign ready_o   = !path_ld_i & (!final_beat | !vld_p1 | ready_i);
   assign accept    = valid_i & ready_o;
   assign new_final = accept & final_beat;

   // ---- stage 1: config, beat counter, output valid ----
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         en_cfg_p1  <= '0;
         sel_cfg_p1 <= '0;
         acc_len_p1 <= ACC_LEN_W'(1);
         cnt_p1     <= '0;
         vld_p1     <= 1'b0;
      end else begin
         if (path_ld_i) begin
            en_cfg_p1  <= en_adder_i;
            sel_cfg_p1 <= sel_mux_i;
            acc_len_p1 <= acc_len_i;
            cnt_p1     <= '0;
         end else if (accept) begin
            cnt_p1 <= final_beat ? '0 : cnt_p1 + ACC_LEN_W'(1);
         end

         if (new_final)
            vld_p1 <= 1'b1;
         else if (ready_i)
            vld_p1 <= 1'b0;
      end
   end

   assign en_adder_o = en_cfg_p1;
   assign sel_mux_o  = sel_cfg_p1;
   assign valid_o    = vld_p1;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      vnode_lane #(
         .D (D)
      ) u_lane (
         .clk_i    (clk_i),
         .rst_n_i  (rst_n_i),
         .en_adder (en_cfg_p1[k]),
         .sel_mux  (sel_cfg_p1[k]),
         .beat     (accept),
         .first    (first),
         .load_out (new_final),
         .clr      (path_ld_i),
         .top      (top_data_i[k*D +: D]),
         .mux      (mux_data_i[k*D +: D]),
         .out      (out_data_o[k*D +: D]),
         .ovf      (ovf_o[k])
      );
   end

endmodule

// File: tb/tb_vertical_node_mc.sv
module tb_vertical_node_mc;

   localparam int LANES     = 4;
   localparam int D         = 16;
   localparam int ACC_LEN_W = 4;

   logic                 clk = 1'b0;
   logic                 rst_n_i;
   logic                 path_ld_i;
   logic [LANES-1:0]     en_adder_i;
   logic [LANES-1:0]     sel_mux_i;
   logic [ACC_LEN_W-1:0] acc_len_i;
   logic [LANES-1:0]     en_adder_o;
   logic [LANES-1:0]     sel_mux_o;
   logic [LANES*D-1:0]   top_data_i;
   logic [LANES*D-1:0]   mux_data_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [LANES*D-1:0]   out_data_o;
   logic                 valid_o;
   logic                 ready_i;
   logic [LANES-1:0]     ovf_o;

   logic [LANES*D-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vertical_node_mc dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n_i),
      .path_ld_i  (path_ld_i),
      .en_adder_i (en_adder_i),
      .sel_mux_i  (sel_mux_i),
      .acc_len_i  (acc_len_i),
      .en_adder_o (en_adder_o),
      .sel_mux_o  (sel_mux_o),
      .top_data_i (top_data_i),
      .mux_data_i (mux_data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .out_data_o (out_data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .ovf_o      (ovf_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [LANES*D-1:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                             input logic [15:0] l2, input logic [15:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   // Scoreboard monitor: an output word transfers on an edge where
   // valid_o & ready_i; it is inspected on the preceding falling edge.
   always @(negedge clk) begin
      if (rst_n_i && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", out_data_o);
         end else begin
            chk("sb_out_data", 64'(out_data_o), 64'(exp_q.pop_front()));
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that
   // loaded the config.
   task automatic load(input logic [3:0] en, input logic [3:0] sel, input logic [3:0] len);
      path_ld_i  = 1'b1;
      en_adder_i = en;
      sel_mux_i  = sel;
      acc_len_i  = len;
      @(negedge clk);
      chk("ld_ready_low", 64'(ready_o), 64'd0);
      @(posedge clk);
      #1;
      path_ld_i = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [LANES*D-1:0] t, input logic [LANES*D-1:0] m);
      int  n;
      logic took;
      top_data_i = t;
      mux_data_i = m;
      valid_i    = 1'b1;
      n          = 0;
      took       = 1'b0;
      while (!took && n < 50) begin
         @(negedge clk);
         took = ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      if (!took) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=ready_low required=accept");
      end
      valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i    = 1'b0;
      path_ld_i  = 1'b0;
      en_adder_i = '0;
      sel_mux_i  = '0;
      acc_len_i  = '0;
      top_data_i = '0;
      mux_data_i = '0;
      valid_i    = 1'b0;
      ready_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_valid", 64'(valid_o), 64'd0);
      chk("init_out", 64'(out_data_o), 64'd0);
      rst_n_i = 1'b1;

      // Reset in the middle of traffic: bypass-accumulate 5+7, output held.
      load(4'hF, 4'hF, 4'd2);
      send(pk(16'd5, 16'd0, 16'd0, 16'd0), pk(16'd9, 16'd0, 16'd0, 16'd0));
      send(pk(16'd7, 16'd0, 16'd0, 16'd0), pk(16'd9, 16'd0, 16'd0, 16'd0));
      chk("pre_rst_valid", 64'(valid_o), 64'd1);
      chk("pre_rst_out", 64'(out_data_o), 64'(pk(16'd12, 16'd0, 16'd0, 16'd0)));
      chk("pre_rst_en_o", 64'(en_adder_o), 64'hF);
      chk("pre_rst_sel_o", 64'(sel_mux_o), 64'hF);
      rst_n_i = 1'b0;
      @(posedge clk);
      #1;
      rst_n_i = 1'b1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_out", 64'(out_data_o), 64'd0);
      chk("rst_en_o", 64'(en_adder_o), 64'd0);
      chk("rst_sel_o", 64'(sel_mux_o), 64'd0);
      chk("rst_ovf", 64'(ovf_o), 64'd0);
      @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;
      ready_i = 1'b1;

      // Default config after reset: acc_len=1, result = local operand.
      exp_q.push_back(pk(16'h00AB, 16'd0, 16'd0, 16'd0));
      send(pk(16'h1111, 16'd0, 16'd0, 16'd0), pk(16'h00AB, 16'd0, 16'd0, 16'd0));

      // Add: 100 + (-30) = 70.
      load(4'hF, 4'h0, 4'd1);
      exp_q.push_back(pk(16'd70, 16'd0, 16'd0, 16'd0));
      send(pk(16'd100, 16'd0, 16'd0, 16'd0), pk(-16'sd30, 16'd0, 16'd0, 16'd0));

      // Bypass on lane 2, add elsewhere.
      load(4'hF, 4'b0100, 4'd1);
      exp_q.push_back(pk(16'd11, 16'd22, 16'h1234, 16'd33));
      send(pk(16'd1, 16'd2, 16'h1234, 16'd3), pk(16'd10, 16'd20, 16'h0001, 16'd30));

      // Positive overflow on lane 0, negative overflow on lane 1.
      load(4'hF, 4'h0, 4'd1);
`ifdef VNODE_SAT_EN
      exp_q.push_back(pk(16'h7FFF, 16'h8000, 16'd0, 16'd0));
`else
      exp_q.push_back(pk(16'h8100, 16'h7FFF, 16'd0, 16'd0));
`endif
      send(pk(16'h7F00, 16'h8000, 16'd0, 16'd0), pk(16'h0200, 16'hFFFF, 16'd0, 16'd0));
`ifdef VNODE_SAT_EN
      chk("ovf_set", 64'(ovf_o), 64'h3);
`else
      chk("ovf_set", 64'(ovf_o), 64'h0);
`endif
      exp_q.push_back(pk(16'd2, 16'd4, 16'd0, 16'd0));
      send(pk(16'd1, 16'd2, 16'd0, 16'd0), pk(16'd1, 16'd2, 16'd0, 16'd0));
`ifdef VNODE_SAT_EN
      chk("ovf_sticky", 64'(ovf_o), 64'h3);
`else
      chk("ovf_sticky", 64'(ovf_o), 64'h0);
`endif

      // Accumulate 1+2+3 over acc_len=3; load clears ovf.
      load(4'hF, 4'h0, 4'd3);
      chk("ovf_cleared", 64'(ovf_o), 64'h0);
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      chk("acc_beat1_valid", 64'(valid_o), 64'd0);
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd1, 16'd0, 16'd0, 16'd0));
      chk("acc_beat2_valid", 64'(valid_o), 64'd0);
      exp_q.push_back(pk(16'd6, 16'd0, 16'd0, 16'd0));
      send(pk(16'd2, 16'd0, 16'd0, 16'd0), pk(16'd1, 16'd0, 16'd0, 16'd0));
      chk("acc_beat3_valid", 64'(valid_o), 64'd1);

      // Abort after two beats; three fresh beats of 1 give 3.
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      load(4'hF, 4'h0, 4'd3);
      chk("abort_valid", 64'(valid_o), 64'd0);
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      exp_q.push_back(pk(16'd3, 16'd0, 16'd0, 16'd0));
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));

      // Overflow in the accumulate step: 0x7000 + 0x7000.
      load(4'hF, 4'h0, 4'd2);
      send(pk(16'h7000, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
`ifdef VNODE_SAT_EN
      chk("acc_ovf_first", 64'(ovf_o), 64'h0);
      exp_q.push_back(pk(16'h7FFF, 16'd0, 16'd0, 16'd0));
`else
      exp_q.push_back(pk(16'hE000, 16'd0, 16'd0, 16'd0));
`endif
      send(pk(16'h7000, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
`ifdef VNODE_SAT_EN
      chk("acc_ovf", 64'(ovf_o), 64'h1);
`else
      chk("acc_ovf", 64'(ovf_o), 64'h0);
`endif

      // Backpressure with acc_len=2.
      load(4'hF, 4'h0, 4'd2);
      ready_i = 1'b0;
      send(pk(16'd1, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      exp_q.push_back(pk(16'd3, 16'd0, 16'd0, 16'd0));
      send(pk(16'd2, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_out", 64'(out_data_o), 64'(pk(16'd3, 16'd0, 16'd0, 16'd0)));
      send(pk(16'd10, 16'd0, 16'd0, 16'd0), pk(16'd0, 16'd0, 16'd0, 16'd0));
      top_data_i = pk(16'd20, 16'd0, 16'd0, 16'd0);
      mux_data_i = '0;
      valid_i    = 1'b1;
      @(negedge clk);
      chk("bp_final_ready", 64'(ready_o), 64'd0);
      @(negedge clk);
      chk("bp_final_ready2", 64'(ready_o), 64'd0);
      chk("bp_out_stable", 64'(out_data_o), 64'(pk(16'd3, 16'd0, 16'd0, 16'd0)));
      @(posedge clk);
      #1;
      exp_q.push_back(pk(16'd30, 16'd0, 16'd0, 16'd0));
      ready_i = 1'b1;
      @(negedge clk);
      chk("bp_drain_ready", 64'(ready_o), 64'd1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      chk("bp_new_valid", 64'(valid_o), 64'd1);
      chk("bp_new_out", 64'(out_data_o), 64'(pk(16'd30, 16'd0, 16'd0, 16'd0)));

      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      chk("final_valid", 64'(valid_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vertical_node_mc.md
Name: vertical_node_mc

Overview:
Multi-lane, handshaked successor to the single-lane vertical adder node in the systolic PE column. Per lane it either bypasses the top-neighbour operand or adds it to the local mux operand, optionally accumulating over a programmable number of beats. It forwards per-lane path configuration downward for chaining and flags arithmetic overflow per lane. Sits between PE rows in the vertical reduction path, feeding the column output collector.

Parameters:
F_WIDTH, 8, fractional bits per lane word
I_WIDTH, 8, integer bits per lane word; lane width D = I_WIDTH+F_WIDTH, signed two's complement
LANES, 4, number of independent lanes (channels)
ACC_LEN_W, 4, width of the accumulation-length field

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_n_i  in  1  synchronous active-low reset
path_ld_i  in  1  load per-lane config and acc_len; aborts any accumulation in progress
en_adder_i  in  LANES  per-lane adder enable (config)
sel_mux_i  in  LANES  per-lane bypass select (config)
acc_len_i  in  ACC_LEN_W  beats per output (config)
en_adder_o  out  LANES  registered en_adder config, for the next node
sel_mux_o  out  LANES  registered sel_mux config, for the next node
top_data_i  in  LANES*D  top-neighbour operands, lane k at [k*D +: D]
mux_data_i  in  LANES*D  local operands
valid_i  in  1  input beat valid
ready_o  out  1  node can accept a beat
out_data_o  out  LANES*D  registered result
valid_o  out  1  out_data_o valid
ready_i  in  1  downstream accepts
ovf_o  out  LANES  sticky per-lane overflow flag

Behaviour:
- Reset (rst_n_i=0 at an edge): valid_o=0, out_data_o=0, en_adder_o=0, sel_mux_o=0, ovf_o=0, acc_len=1, beat counter=0, accumulators=0. ready_o=1 after reset.
- Config: on path_ld_i=1, en_adder_o, sel_mux_o and acc_len register the inputs next edge. Counter and accumulators clear and ovf_o clears. An input beat in the same cycle is dropped, and ready_o=0 in that cycle. A pending valid_o/out_data_o is retained.
- Beat accepted: valid_i & ready_o.
- Per-lane result r: sel_mux=1 -> r=top. Else en_adder=1 -> r=top+mux. Else r=mux.
- Accumulation: acc_len 0 or 1 -> every beat is final. Otherwise: cnt==0 -> acc=r, else acc=acc+r. cnt increments. The beat with cnt==acc_len-1 is final and cnt returns to 0.
- Final beat: out_data_o <= acc_next (or r), valid_o <= 1 next edge. Latency is 1 cycle from the final accepted beat.
- Non-final beats never touch out_data_o or valid_o.
- Handshake: ready_o = !path_ld_i & (nonfinal_beat | !valid_o | ready_i). valid_o clears on ready_i & !new_final. Simultaneous drain and final load keeps valid_o=1 with the new data. out_data_o is stable while valid_o & !ready_i.
- Arithmetic: full (D+1)-bit sum. Overflow when the result is outside [-2^(D-1), 2^(D-1)-1]. Both add and accumulate steps are checked. Bypass never overflows.

Optional Feature:
VNODE_SAT_EN
- Defined: an overflowing result clamps to 2^(D-1)-1 or -2^(D-1), and the lane's ovf_o sets, sticky until path_ld_i or reset.
- Undefined: two's-complement wrap to D bits. ovf_o is tied to 0.

Decomposition:
- Package vnode_pkg: lane width function D(I_WIDTH,F_WIDTH), SAT_MAX/SAT_MIN constants, overflow-detect and saturate functions.
- Sub-module vnode_lane: per-lane mux/add/accumulate/saturate datapath plus ovf flag, generated LANES times.
- Top-level vertical_node_mc owns the config registers, beat counter, handshake and valid_o.

Test Plan:
(Default parameters, D=16.)
1. Reset: hold rst_n_i=0 one edge mid-traffic -> valid_o=0, out_data_o=0, en/sel_o=0, ovf_o=0; ready_o=1 next cycle.
2. Add: load en=4'hF, sel=0, acc_len=1; beat with lane0 top=100, mux=-30 -> next cycle valid_o=1, lane0=70.
3. Bypass: sel_mux lane2=1, top=16'h1234, mux=16'h0001 -> lane2 out 16'h1234, other lanes top+mux.
4. Overflow: lane0 top=16'h7F00, mux=16'h0200 -> with VNODE_SAT_EN out=16'h7FFF and ovf_o[0]=1 (stays 1 over later clean beats); without the macro out=16'h8100 and ovf_o=0.
5. Accumulate: acc_len=3, lane0 results 1,2,3 on consecutive beats -> valid_o only after the 3rd beat, lane0=6. A path_ld_i after 2 beats aborts: the next 3 beats of 1 give 3.
6. Backpressure: acc_len=2, valid_o=1 held with ready_i=0 -> first beat accepted (ready_o=1), final beat ready_o=0 and out_data_o unchanged. Raise ready_i -> final beat accepted same cycle, new result next edge with valid_o staying 1.
